// File: rtl/spio_hss_multiplexer_frame_sched_pkg.sv
// Shared widths and FSM encodings for the HSS multiplexer frame scheduler, plus the common header defines.
// Pure declarations: no latency and no flow control of its own.
`ifndef SPIO_HSS_MULTIPLEXER_COMMON_H
`define SPIO_HSS_MULTIPLEXER_COMMON_H
`define FRM_BITS        32
`define KCH_BITS        4
`define NUM_CHANS       8
`define IDLE_ST         1'b0
`define SEND_ST         1'b1
`define SCHED_STAT_BITS 16
`endif

package spio_hss_multiplexer_frame_sched_pkg;

    localparam int FRM_BITS        = `FRM_BITS;
    localparam int KCH_BITS        = `KCH_BITS;
    localparam int NUM_CHANS       = `NUM_CHANS;
    localparam int SCHED_STAT_BITS = `SCHED_STAT_BITS;

    typedef enum logic {
        IDLE_ST = `IDLE_ST,
        SEND_ST = `SEND_ST
    } sched_state_t;

endpackage

// File: rtl/spio_hss_multiplexer_rr_arb.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping modulo NUM_CH.
// Zero latency; no flow control of its own.
module spio_hss_multiplexer_rr_arb #(
    parameter int NUM_CH  = 8,
    parameter int CH_BITS = 3
) (
    input  logic [NUM_CH-1:0]  elig,
    input  logic [CH_BITS-1:0] ptr,
    output logic               any,
    output logic [CH_BITS-1:0] idx
);

    int                 j;
    logic [CH_BITS-1:0] jj;

    // Walk from the farthest offset back to ptr so the nearest eligible index wins.
    always_comb begin
        any = |elig;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j  = (int'(ptr) + k) % NUM_CH;
            jj = CH_BITS'(j);
            if (elig[jj]) begin
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_frame_sched.sv
// Frame-granular round-robin scheduler; grant 1 cycle after a request, one idle bubble between frames.
// Granted channel passes straight through (frm_rdy -> ch_rdy); optional stats under SPIO_HSS_SCHED_STATS_EN.
module spio_hss_multiplexer_frame_sched
    import spio_hss_multiplexer_frame_sched_pkg::*;
#(
    parameter int NUM_CH  = NUM_CHANS,
    parameter int CH_BITS = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*FRM_BITS-1:0]   ch_data,
    input  logic [NUM_CH*KCH_BITS-1:0]   ch_kchr,
    input  logic [NUM_CH-1:0]            ch_last,
    input  logic [NUM_CH-1:0]            ch_vld,
    output logic [NUM_CH-1:0]            ch_rdy,
    input  logic [NUM_CH-1:0]            cfc_rem,
    output logic [FRM_BITS-1:0]          frm_data,
    output logic [KCH_BITS-1:0]          frm_kchr,
    output logic                         frm_last,
    output logic                         frm_vld,
    input  logic                         frm_rdy,
    output logic                         sched_busy,
`ifdef SPIO_HSS_SCHED_STATS_EN
    input  logic [CH_BITS-1:0]           stat_sel,
    output logic [SCHED_STAT_BITS-1:0]   stat_cnt,
`endif
    output logic [CH_BITS-1:0]           sched_chan
);

    sched_state_t       state_q;
    logic [CH_BITS-1:0] ptr_q;
    logic [CH_BITS-1:0] grant_q;
    logic               busy_q;

    logic [NUM_CH-1:0]   elig;
    logic                arb_any;
    logic [CH_BITS-1:0]  arb_idx;
    logic                frm_end;

    logic [FRM_BITS-1:0] data_a [NUM_CH];
    logic [KCH_BITS-1:0] kchr_a [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign data_a[i] = ch_data[i*FRM_BITS +: FRM_BITS];
        assign kchr_a[i] = ch_kchr[i*KCH_BITS +: KCH_BITS];
    end

    // Remote stop only gates the start of a frame; mid-frame it is ignored.
    assign elig    = ch_vld & ~cfc_rem;
    assign frm_end = frm_vld & frm_rdy & frm_last;

    spio_hss_multiplexer_rr_arb #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_arb (
        .elig (elig),
        .ptr  (ptr_q),
        .any  (arb_any),
        .idx  (arb_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_ST;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE_ST: begin
                    if (arb_any) begin
                        grant_q <= arb_idx;
                        busy_q  <= 1'b1;
                        state_q <= SEND_ST;
                    end
                end
                SEND_ST: begin
                    if (frm_end) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE_ST;
                        ptr_q   <= (grant_q == CH_BITS'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
                default: state_q <= IDLE_ST;
            endcase
        end
    end

    // Outputs are forced quiet outside SEND_ST so an abandoned frame leaves nothing on the bus.
    always_comb begin
        frm_data = '0;
        frm_kchr = '0;
        frm_last = 1'b0;
        frm_vld  = 1'b0;
        ch_rdy   = '0;
        if (state_q == SEND_ST) begin
            frm_data        = data_a[grant_q];
            frm_kchr        = kchr_a[grant_q];
            frm_last        = ch_last[grant_q];
            frm_vld         = ch_vld[grant_q];
            ch_rdy[grant_q] = frm_rdy;
        end
    end

    assign sched_busy = busy_q;
    assign sched_chan = grant_q;

`ifdef SPIO_HSS_SCHED_STATS_EN
    logic [SCHED_STAT_BITS-1:0] cnt_q [NUM_CH];
    logic [SCHED_STAT_BITS-1:0] stat_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            if (frm_end && (cnt_q[grant_q] != {SCHED_STAT_BITS{1'b1}})) begin
                cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
            end
            stat_cnt_q <= cnt_q[stat_sel];
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule
